fetch_queue: RTL and testbench

Instruction-fetch stage directly downstream of the counter/address register acting as program counter. It gates the PC onto the address bus, latches the address and runs a byte read from program memory. It pushes the byte into a small prefetch FIFO for the decode stage, then pulses the counter's inc line to advance the PC. A flush input discards the queue and any in-flight read while the PC is being reloaded for a jump.

---
 rtl/fetch_queue.sv | 145 ++++++++++++++
 tb/tb_fetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: reads program bytes at the PC into a small prefetch FIFO,
// then pulses the counter's inc line. flush drops the queue and any in-flight read.
module fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     fetch_en,
    input  logic                     flush,
    input  logic [15:0]              addr_in,
    output logic                     a_addr_n,
    output logic                     inc,
    output logic [15:0]              mem_addr,
    output logic                     mem_rd_n,
    input  logic [7:0]               mem_data,
    input  logic                     mem_ready,
    output logic [7:0]               instr_data,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [2:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SETTLE + 2);
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ADDR   = 3'd1,
        S_READ   = 3'd2,
        S_INC    = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t          state;
    logic [SW-1:0]   settle_cnt;
    logic [7:0]      fifo_mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            push;
    logic            pop;
    logic            can_start;

    // Handshakes: decode takes the head on any cycle where instr_valid & instr_ready;
    // memory delivers mem_data on any cycle where mem_rd_n is low and mem_ready is high.
    // A flush cycle blocks both transfers.
    assign push      = (state == S_READ) && mem_ready && !flush;
    assign pop       = (count != '0) && instr_ready && !flush;
    // Only one read is ever outstanding, so a free slot now stays free until its push.
    assign can_start = fetch_en && !flush && (count < FULL);

    assign instr_valid = (count != '0);
    assign instr_data  = instr_valid ? fifo_mem[rd_ptr] : 8'h00;
    assign level       = count;
    assign state_dbg   = state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            a_addr_n   <= 1'b1;
            inc        <= 1'b0;
            mem_rd_n   <= 1'b1;
            mem_addr   <= 16'h0000;
            settle_cnt <= '0;
        end else if (flush) begin
            state      <= S_IDLE;
            a_addr_n   <= 1'b1;
            inc        <= 1'b0;
            mem_rd_n   <= 1'b1;
            settle_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (can_start) begin
                        state    <= S_ADDR;
                        a_addr_n <= 1'b0;
                    end
                end
                S_ADDR: begin
                    mem_addr <= addr_in;
                    a_addr_n <= 1'b1;
                    mem_rd_n <= 1'b0;
                    state    <= S_READ;
                end
                S_READ: begin
                    if (mem_ready) begin
                        mem_rd_n <= 1'b1;
                        inc      <= 1'b1;
                        state    <= S_INC;
                    end
                end
                S_INC: begin
                    inc        <= 1'b0;
                    settle_cnt <= '0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    // SETTLE quiet cycles for the counter, then one cycle to re-sample the PC.
                    if (settle_cnt == SW'(SETTLE)) begin
                        settle_cnt <= '0;
                        if (can_start) begin
                            state    <= S_ADDR;
                            a_addr_n <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) fifo_mem[wr_ptr] <= mem_data;
    end

    assert property (@(posedge clock) disable iff (!reset_n) !(push && (count == FULL)));

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a PC counter model and a byte-per-address memory
// (data at address A is {A[3:0]+1, A[3:0]+1}).
module tb_fetch_queue;

    localparam int DEPTH  = 4;
    localparam int SETTLE = 2;

    logic                   clock = 1'b0;
    logic                   reset_n = 1'b1;
    logic                   fetch_en = 1'b0;
    logic                   flush = 1'b0;
    logic [15:0]            addr_in;
    logic                   a_addr_n;
    logic                   inc;
    logic [15:0]            mem_addr;
    logic                   mem_rd_n;
    logic [7:0]             mem_data;
    logic                   mem_ready;
    logic [7:0]             instr_data;
    logic                   instr_valid;
    logic                   instr_ready = 1'b0;
    logic [$clog2(DEPTH):0] level;
    logic [2:0]             state_dbg;

    fetch_queue #(.DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clock(clock), .reset_n(reset_n), .fetch_en(fetch_en), .flush(flush),
        .addr_in(addr_in), .a_addr_n(a_addr_n), .inc(inc), .mem_addr(mem_addr),
        .mem_rd_n(mem_rd_n), .mem_data(mem_data), .mem_ready(mem_ready),
        .instr_data(instr_data), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .level(level), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clock = ~clock;

    // program counter: advances on a rising inc, loadable for jumps
    logic [15:0] pc;
    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = 16'h0000;
    logic        inc_d = 1'b0;
    always @(posedge clock) begin
        inc_d <= inc;
        if (pc_load) pc <= pc_load_val;
        else if (inc && !inc_d) pc <= pc + 16'd1;
    end
    assign addr_in = pc;

    // program memory with programmable wait states and a hold switch
    int   wait_states = 0;
    logic mem_hold = 1'b0;
    int   wcnt = 0;
    always @(posedge clock) wcnt <= mem_rd_n ? 0 : wcnt + 1;
    assign mem_ready = !mem_rd_n && (wcnt >= wait_states) && !mem_hold;
    assign mem_data  = {mem_addr[3:0] + 4'd1, mem_addr[3:0] + 4'd1};

    // bus monitor
    int          cyc = 0;
    int          push_cnt = 0;
    int          inc_cnt = 0;
    int          rdlow_cnt = 0;
    int          rd_run = 0;
    int          stab_err = 0;
    int          overlap_err = 0;
    int          inc_err = 0;
    logic        read_done = 1'b0;
    logic [15:0] addr_hold = 16'h0000;
    logic [15:0] got_addr[$];
    int          push_cyc[$];
    logic [7:0]  pop_q[$];
    always @(posedge clock) begin
        cyc++;
        if (reset_n) begin
            if (!a_addr_n && !mem_rd_n) overlap_err++;
            if (!mem_rd_n) begin
                if (rd_run == 0) addr_hold = mem_addr;
                else if (mem_addr !== addr_hold) stab_err++;
                rd_run++;
                rdlow_cnt++;
            end else begin
                rd_run = 0;
            end
            if (inc) begin
                if (!read_done) inc_err++;
                read_done = 1'b0;
                inc_cnt++;
            end
            if (!mem_rd_n && mem_ready && !flush) begin
                push_cnt++;
                got_addr.push_back(mem_addr);
                push_cyc.push_back(cyc);
                read_done = 1'b1;
            end
            if (instr_valid && instr_ready && !flush) pop_q.push_back(instr_data);
        end
    end

    // scoreboard
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         pop_rd = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_pops(input string tag, input int n);
        chk({tag, "_count"}, pop_q.size() - pop_rd, n);
        while (pop_rd < pop_q.size() && exp_q.size() > 0) begin
            chk(tag, {24'h0, pop_q[pop_rd]}, {24'h0, exp_q.pop_front()});
            pop_rd++;
        end
        pop_rd = pop_q.size();
        exp_q.delete();
    endtask

    int base_push, base_inc, base_addr, base_low;

    initial begin
        #1 reset_n = 1'b0;
        pc_load = 1'b1; pc_load_val = 16'h0100;
        step(3);
        chk("rst_a_addr_n", a_addr_n, 1);
        chk("rst_inc", inc, 0);
        chk("rst_mem_rd_n", mem_rd_n, 1);
        chk("rst_mem_addr", mem_addr, 16'h0000);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 8'h00);
        chk("rst_level", level, 0);
        chk("rst_state", state_dbg, 0);
        pc_load = 1'b0;
        reset_n = 1'b1;
        step(2);
        chk("idle_no_en", state_dbg, 0);

        // zero-wait streaming of three bytes
        base_push = push_cnt; base_inc = inc_cnt; base_addr = got_addr.size();
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        instr_ready = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 100 && (push_cnt - base_push) < 3; i++) step(1);
        fetch_en = 1'b0;
        chk("t1_pushes", push_cnt - base_push, 3);
        step(12);
        chk("t1_addr0", got_addr[base_addr],     16'h0100);
        chk("t1_addr1", got_addr[base_addr + 1], 16'h0101);
        chk("t1_addr2", got_addr[base_addr + 2], 16'h0102);
        chk("t1_gap0", push_cyc[base_addr + 1] - push_cyc[base_addr], 6);
        chk("t1_gap1", push_cyc[base_addr + 2] - push_cyc[base_addr + 1], 6);
        chk("t1_incs", inc_cnt - base_inc, 3);
        check_pops("t1_pop", 3);
        chk("t1_idle", state_dbg, 0);
        chk("t1_pc", pc, 16'h0103);

        // decode stalled: queue fills to DEPTH and fetching stops
        instr_ready = 1'b0;
        base_push = push_cnt;
        exp_q.push_back(8'h44); exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        exp_q.push_back(8'h77); exp_q.push_back(8'h88);
        fetch_en = 1'b1;
        step(40);
        chk("t2_reads4", push_cnt - base_push, 4);
        chk("t2_level4", level, 4);
        chk("t2_state", state_dbg, 0);
        chk("t2_a_addr_n", a_addr_n, 1);
        chk("t2_head", instr_data, 8'h44);
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        chk("t2_level3", level, 3);
        step(20);
        chk("t2_reads5", push_cnt - base_push, 5);
        chk("t2_refill", level, 4);
        fetch_en = 1'b0;
        instr_ready = 1'b1;
        step(8);
        check_pops("t2_pop", 5);
        chk("t2_drained", level, 0);
        chk("t2_pc", pc, 16'h0108);

        // five wait states on one read
        instr_ready = 1'b1;
        wait_states = 5;
        base_push = push_cnt; base_inc = inc_cnt; base_addr = got_addr.size(); base_low = rdlow_cnt;
        exp_q.push_back(8'h99);
        fetch_en = 1'b1;
        step(1);
        fetch_en = 1'b0;
        step(25);
        chk("t3_rd_low", rdlow_cnt - base_low, 6);
        chk("t3_addr_stable", stab_err, 0);
        chk("t3_pushes", push_cnt - base_push, 1);
        chk("t3_incs", inc_cnt - base_inc, 1);
        chk("t3_addr", got_addr[base_addr], 16'h0108);
        check_pops("t3_pop", 1);
        wait_states = 0;

        // flush mid-read with two bytes queued and a coincident mem_ready
        instr_ready = 1'b0;
        base_push = push_cnt;
        fetch_en = 1'b1;
        for (int i = 0; i < 60 && (push_cnt - base_push) < 2; i++) step(1);
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && mem_rd_n !== 1'b0; i++) step(1);
        step(2);
        chk("t4_level2", level, 2);
        chk("t4_in_read", state_dbg, 2);
        mem_hold = 1'b0;
        flush = 1'b1;
        step(1);
        chk("t4_level0", level, 0);
        chk("t4_valid0", instr_valid, 0);
        chk("t4_rd_n", mem_rd_n, 1);
        chk("t4_a_addr_n", a_addr_n, 1);
        chk("t4_state", state_dbg, 0);
        step(3);
        chk("t4_hold_idle", state_dbg, 0);
        chk("t4_hold_level", level, 0);
        pc_load = 1'b1; pc_load_val = 16'h2000;
        step(1);
        pc_load = 1'b0;
        flush = 1'b0;
        base_addr = got_addr.size();
        exp_q.push_back(8'h11);
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && got_addr.size() <= base_addr; i++) step(1);
        fetch_en = 1'b0;
        chk("t4_jump_addr", got_addr[base_addr], 16'h2000);
        step(10);
        check_pops("t4_pop", 1);

        // push and pop in the same cycle at level 1, then pops on an empty queue
        instr_ready = 1'b0;
        base_push = push_cnt;
        fetch_en = 1'b1;
        for (int i = 0; i < 30 && (push_cnt - base_push) < 1; i++) step(1);
        mem_hold = 1'b1;
        for (int i = 0; i < 20 && mem_rd_n !== 1'b0; i++) step(1);
        fetch_en = 1'b0;
        chk("t5_level1", level, 1);
        exp_q.push_back(8'h22);
        mem_hold = 1'b0;
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        chk("t5_level_same", level, 1);
        chk("t5_head", instr_data, 8'h33);
        step(8);
        exp_q.push_back(8'h33);
        instr_ready = 1'b1;
        step(1);
        chk("t5_level0", level, 0);
        step(2);
        chk("t5_empty_pop_level", level, 0);
        chk("t5_empty_valid", instr_valid, 0);
        chk("t5_empty_data", instr_data, 8'h00);
        instr_ready = 1'b0;
        check_pops("t5_pop", 2);

        // asynchronous reset during INC, then a clean restart
        fetch_en = 1'b1;
        for (int i = 0; i < 30 && inc !== 1'b1; i++) step(1);
        chk("t6_saw_inc", inc, 1);
        reset_n = 1'b0;
        #1;
        chk("t6_inc", inc, 0);
        chk("t6_a_addr_n", a_addr_n, 1);
        chk("t6_rd_n", mem_rd_n, 1);
        chk("t6_mem_addr", mem_addr, 16'h0000);
        chk("t6_level", level, 0);
        chk("t6_valid", instr_valid, 0);
        chk("t6_state", state_dbg, 0);
        step(2);
        reset_n = 1'b1;
        base_addr = got_addr.size();
        exp_q.push_back(8'h44);
        instr_ready = 1'b1;
        for (int i = 0; i < 30 && got_addr.size() <= base_addr; i++) step(1);
        fetch_en = 1'b0;
        chk("t6_restart_addr", got_addr[base_addr], 16'h2003);
        step(10);
        check_pops("t6_pop", 1);

        chk("bus_overlap", overlap_err, 0);
        chk("inc_without_read", inc_err, 0);
        chk("addr_stable_all", stab_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
